// File: rtl/bpred_table_sched.sv
// Scheduler for the single-ported gselect counter table: clears the table after reset,
// queues execute-stage counter updates, and arbitrates the port between lookups and writes.
module bpred_table_sched #(
  parameter int unsigned IDX_W      = 12,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STARVE_MAX = 8,
  parameter logic [1:0]  INIT_VAL   = 2'b01
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_req,
  input  logic [IDX_W-1:0] fetch_idx,
  output logic             fetch_gnt,
  output logic             fetch_stall,
  input  logic             ex_upd_valid,
  input  logic [IDX_W-1:0] ex_upd_idx,
  input  logic             ex_upd_dir,
  input  logic [1:0]       ex_upd_ctr,
  output logic             ex_upd_ready,
  output logic             tbl_en,
  output logic             tbl_we,
  output logic [IDX_W-1:0] tbl_addr,
  output logic [1:0]       tbl_wdata,
  output logic             init_busy,
  output logic [15:0]      stall_cnt
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [0:0] {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   init_ptr;
  logic [IDX_W-1:0]   fifo_idx [FIFO_DEPTH];
  logic [1:0]         fifo_ctr [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [STV_W-1:0]   starve_cnt;
  logic               push, pop, fifo_nonempty, force_upd;
  logic [1:0]         new_ctr;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_INIT;
    else        state <= state_nxt;
  end

  // Next-state: leave INIT once the last entry has been written
  always_comb begin
    state_nxt = state;
    if (state == S_INIT && init_ptr == {IDX_W{1'b1}}) state_nxt = S_RUN;
  end

  assign fifo_nonempty = (count != '0);
  assign force_upd     = fifo_nonempty &&
                         (count == CNT_W'(FIFO_DEPTH) || starve_cnt == STV_W'(STARVE_MAX));

  // Port arbitration: forced update > fetch lookup > opportunistic update
  always_comb begin
    tbl_en       = 1'b0;
    tbl_we       = 1'b0;
    tbl_addr     = '0;
    tbl_wdata    = '0;
    fetch_gnt    = 1'b0;
    pop          = 1'b0;
    init_busy    = (state == S_INIT);
    ex_upd_ready = (state == S_RUN) && (count < CNT_W'(FIFO_DEPTH));
    if (state == S_INIT) begin
      tbl_en    = 1'b1;
      tbl_we    = 1'b1;
      tbl_addr  = init_ptr;
      tbl_wdata = INIT_VAL;
    end else if (force_upd || (!fetch_req && fifo_nonempty)) begin
      tbl_en    = 1'b1;
      tbl_we    = 1'b1;
      tbl_addr  = fifo_idx[rd_ptr];
      tbl_wdata = fifo_ctr[rd_ptr];
      pop       = 1'b1;
    end else if (fetch_req) begin
      tbl_en    = 1'b1;
      tbl_addr  = fetch_idx;
      fetch_gnt = 1'b1;
    end
  end

  assign fetch_stall = fetch_req & ~fetch_gnt;
  assign push        = ex_upd_valid & ex_upd_ready;

  // 2-bit saturating counter step, applied before the entry is queued
  always_comb begin
    new_ctr = ex_upd_ctr;
    if (ex_upd_dir) begin
      if (ex_upd_ctr != 2'd3) new_ctr = ex_upd_ctr + 2'd1;
    end else begin
      if (ex_upd_ctr != 2'd0) new_ctr = ex_upd_ctr - 2'd1;
    end
  end

  // FIFO payload storage
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx[wr_ptr] <= ex_upd_idx;
      fifo_ctr[wr_ptr] <= new_ctr;
    end
  end

  // Control state: init sweep pointer, FIFO pointers, starvation and stall counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      init_ptr   <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (state == S_INIT) init_ptr <= init_ptr + IDX_W'(1);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (pop || !fifo_nonempty)
        starve_cnt <= '0;
      else if (fetch_gnt && starve_cnt != STV_W'(STARVE_MAX))
        starve_cnt <= starve_cnt + STV_W'(1);
      if (state == S_RUN && fetch_stall && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_bpred_table_sched.sv
// Directed bench for bpred_table_sched: every table write in RUN is matched
// against a scoreboard of updates queued when the bench drives them.
module tb_bpred_table_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       fetch_req;
  logic [3:0] fetch_idx;
  logic       fetch_gnt;
  logic       fetch_stall;
  logic       ex_upd_valid;
  logic [3:0] ex_upd_idx;
  logic       ex_upd_dir;
  logic [1:0] ex_upd_ctr;
  logic       ex_upd_ready;
  logic       tbl_en;
  logic       tbl_we;
  logic [3:0] tbl_addr;
  logic [1:0] tbl_wdata;
  logic       init_busy;
  logic [15:0] stall_cnt;

  typedef struct packed {
    logic [3:0] addr;
    logic [1:0] data;
  } wr_t;

  wr_t sb[$];
  int  checks   = 0;
  int  failures = 0;

  bpred_table_sched #(
    .IDX_W(4), .FIFO_DEPTH(4), .STARVE_MAX(8), .INIT_VAL(2'b01)
  ) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_idx(fetch_idx),
    .fetch_gnt(fetch_gnt), .fetch_stall(fetch_stall),
    .ex_upd_valid(ex_upd_valid), .ex_upd_idx(ex_upd_idx),
    .ex_upd_dir(ex_upd_dir), .ex_upd_ctr(ex_upd_ctr),
    .ex_upd_ready(ex_upd_ready),
    .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .init_busy(init_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] sat_step(input logic dir, input logic [1:0] c);
    if (dir) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    else     return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample at the falling edge; match RUN-mode writes and reads, enqueue accepted updates
  task automatic settle();
    wr_t e;
    @(negedge clk);
    if (!init_busy && tbl_en && tbl_we) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL unexpected_write observed_addr=%0h observed_data=%0h expected=none",
               tbl_addr, tbl_wdata);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(tbl_addr), 32'(e.addr));
        chk("wr_data", 32'(tbl_wdata), 32'(e.data));
      end
    end
    if (fetch_gnt) chk("rd_addr", 32'(tbl_addr), 32'(fetch_idx));
    if (ex_upd_valid && ex_upd_ready)
      sb.push_back('{addr: ex_upd_idx, data: sat_step(ex_upd_dir, ex_upd_ctr)});
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    settle();
    adv();
  endtask

  task automatic drive_upd(input logic [3:0] i, input logic d, input logic [1:0] c);
    ex_upd_valid = 1'b1;
    ex_upd_idx   = i;
    ex_upd_dir   = d;
    ex_upd_ctr   = c;
  endtask

  task automatic init_sweep(input logic req);
    for (int i = 0; i < 16; i++) begin
      settle();
      chk("init_addr", 32'(tbl_addr), 32'(i));
      chk("init_en_we", 32'({tbl_en, tbl_we}), 32'h3);
      chk("init_wdata", 32'(tbl_wdata), 32'h1);
      chk("init_busy", 32'(init_busy), 32'h1);
      chk("init_gnt", 32'(fetch_gnt), 32'h0);
      chk("init_ready", 32'(ex_upd_ready), 32'h0);
      chk("init_stall", 32'(fetch_stall), 32'(req));
      chk("init_stall_cnt", 32'(stall_cnt), 32'h0);
      adv();
    end
  endtask

  initial begin
    reset = 1'b0; fetch_req = 1'b1; fetch_idx = 4'd9;
    ex_upd_valid = 1'b0; ex_upd_idx = '0; ex_upd_dir = 1'b0; ex_upd_ctr = '0;

    // Reset values
    settle();
    chk("rst_busy", 32'(init_busy), 32'h1);
    chk("rst_en_we", 32'({tbl_en, tbl_we}), 32'h3);
    chk("rst_addr", 32'(tbl_addr), 32'h0);
    chk("rst_wdata", 32'(tbl_wdata), 32'h1);
    chk("rst_gnt", 32'(fetch_gnt), 32'h0);
    chk("rst_stall", 32'(fetch_stall), 32'h1);
    chk("rst_ready", 32'(ex_upd_ready), 32'h0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    adv();
    reset = 1'b1;

    // Init sweep with fetch requesting throughout; first grant on cycle 17
    init_sweep(1'b1);
    settle();
    chk("run_gnt", 32'(fetch_gnt), 32'h1);
    chk("run_busy", 32'(init_busy), 32'h0);
    chk("run_stall_cnt", 32'(stall_cnt), 32'h0);
    chk("run_ready", 32'(ex_upd_ready), 32'h1);
    adv();

    // Saturation: idle fetch, three updates written on consecutive cycles
    fetch_req = 1'b0;
    drive_upd(4'd5, 1'b1, 2'd3);
    settle(); chk("sat_idle", 32'(tbl_en), 32'h0); adv();
    drive_upd(4'd6, 1'b0, 2'd0);
    settle(); chk("sat_wr1", 32'(tbl_we), 32'h1); adv();
    drive_upd(4'd7, 1'b1, 2'd1);
    settle(); chk("sat_wr2", 32'(tbl_we), 32'h1); adv();
    ex_upd_valid = 1'b0;
    settle(); chk("sat_wr3", 32'(tbl_we), 32'h1); adv();
    settle(); chk("sat_done", 32'(tbl_en), 32'h0); chk("sat_sb", 32'(sb.size()), 32'h0); adv();

    // Full FIFO under continuous fetch forces a write
    fetch_req = 1'b1; fetch_idx = 4'd3;
    for (int k = 0; k < 4; k++) begin
      drive_upd(4'(8 + k), 1'b1, 2'(k));
      settle();
      chk("full_ready", 32'(ex_upd_ready), 32'h1);
      chk("full_gnt", 32'(fetch_gnt), 32'h1);
      adv();
    end
    ex_upd_valid = 1'b0;
    settle();
    chk("full_not_ready", 32'(ex_upd_ready), 32'h0);
    chk("full_force_gnt", 32'(fetch_gnt), 32'h0);
    chk("full_force_we", 32'(tbl_we), 32'h1);
    chk("full_stall", 32'(fetch_stall), 32'h1);
    chk("full_stall_cnt0", 32'(stall_cnt), 32'h0);
    adv();
    settle();
    chk("full_stall_cnt1", 32'(stall_cnt), 32'h1);
    chk("full_resume", 32'(fetch_gnt), 32'h1);
    adv();
    fetch_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle(); chk("full_drain", 32'(tbl_we), 32'h1); adv();
    end
    settle(); chk("full_idle", 32'(tbl_en), 32'h0); chk("full_sb", 32'(sb.size()), 32'h0); adv();

    // Starvation: one queued update waits exactly 8 fetch grants
    fetch_req = 1'b1; fetch_idx = 4'd11;
    drive_upd(4'd12, 1'b0, 2'd2);
    settle(); chk("stv_push_gnt", 32'(fetch_gnt), 32'h1); adv();
    ex_upd_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      settle(); chk("stv_gnt", 32'(fetch_gnt), 32'h1); adv();
    end
    settle();
    chk("stv_force_gnt", 32'(fetch_gnt), 32'h0);
    chk("stv_force_we", 32'(tbl_we), 32'h1);
    adv();
    settle();
    chk("stv_resume", 32'(fetch_gnt), 32'h1);
    chk("stv_stall_cnt", 32'(stall_cnt), 32'h2);
    adv();

    // Same-cycle push/pop at count 2 across pointer wrap
    drive_upd(4'd0, 1'b1, 2'd0); cycle();
    drive_upd(4'd1, 1'b0, 2'd3); cycle();
    fetch_req = 1'b0;
    for (int k = 2; k < 10; k++) begin
      drive_upd(4'(k), 1'(k), 2'(k >> 1));
      settle();
      chk("pp_ready", 32'(ex_upd_ready), 32'h1);
      chk("pp_pop", 32'(tbl_we), 32'h1);
      adv();
    end
    ex_upd_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      settle(); chk("pp_drain", 32'(tbl_we), 32'h1); adv();
    end
    settle(); chk("pp_count2", 32'(tbl_en), 32'h0); chk("pp_sb", 32'(sb.size()), 32'h0); adv();

    // Reset with three queued updates discards them
    fetch_req = 1'b1; fetch_idx = 4'd6;
    drive_upd(4'd13, 1'b1, 2'd0); cycle();
    drive_upd(4'd14, 1'b1, 2'd1); cycle();
    drive_upd(4'd15, 1'b0, 2'd2); cycle();
    ex_upd_valid = 1'b0;
    cycle();
    reset = 1'b0;
    sb.delete();
    settle();
    chk("mid_rst_busy", 32'(init_busy), 32'h1);
    chk("mid_rst_ready", 32'(ex_upd_ready), 32'h0);
    chk("mid_rst_addr", 32'(tbl_addr), 32'h0);
    chk("mid_rst_gnt", 32'(fetch_gnt), 32'h0);
    chk("mid_rst_stall_cnt", 32'(stall_cnt), 32'h0);
    adv();
    reset = 1'b1; fetch_req = 1'b0;
    init_sweep(1'b0);
    for (int k = 0; k < 6; k++) begin
      settle();
      chk("post_rst_idle", 32'(tbl_en), 32'h0);
      chk("post_rst_ready", 32'(ex_upd_ready), 32'h1);
      adv();
    end
    chk("final_sb", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
